dcsk_rx: RTL

//  Binary DCSK demodulator, the receive end of the chaos-chip serial link. Each message bit

---
 rtl/dcsk_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dcsk_rx.sv
// Binary DCSK demodulator: buffers each reference half-bit, counts data-half mismatches,
// majority-decides each bit and deserialises MSG_W bits LSB first. Optional RX_METRIC_EN adds o_metric/o_ambig.
module dcsk_rx #(
  parameter int MSG_W  = 32,
  parameter int MAX_SF = 16,
  parameter int SF_W   = $clog2(MAX_SF) + 1
) (
  input  logic              i_clk,
  input  logic              i_arst,
  input  logic              i_en,
  input  logic              i_rx,
  input  logic              i_start,
  input  logic [SF_W-1:0]   i_sf,
  output logic              o_busy,
  output logic              o_bit,
  output logic              o_bit_valid,
  output logic [MSG_W-1:0]  o_msg,
  output logic              o_msg_valid,
  output logic              o_err
`ifdef RX_METRIC_EN
  ,
  output logic [SF_W-1:0]   o_metric,
  output logic              o_ambig
`endif
);

  localparam int CW = SF_W - 1;
  localparam int BW = $clog2(MSG_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(MSG_W - 1);

  typedef enum logic [1:0] {IDLE, REF, DATA, DONE} state_t;

  state_t             state, state_nx;
  logic [SF_W-1:0]    sf, mis, m_nx, sf_dec;
  logic [CW-1:0]      sf_last, chip_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [MAX_SF-1:0]  ref_buf;
  logic [MSG_W-1:0]   msg_sr, msg_fin;
  logic               sf_ok, start_ok, start_bad, chip_last, dec_bit, dec_tie;

  assign sf_ok     = (i_sf != '0) && (i_sf <= SF_W'(MAX_SF));
  assign start_ok  = i_start & sf_ok;
  assign start_bad = i_start & ~sf_ok;
  assign sf_dec    = i_sf - 1'b1;
  assign chip_last = (chip_cnt == sf_last);
  assign m_nx      = mis + SF_W'(i_rx ^ ref_buf[chip_cnt]);
  // Compare at SF_W+1 bits so 2*m never wraps; a tie decides 0.
  assign dec_bit   = {m_nx, 1'b0} >  {1'b0, sf};
  assign dec_tie   = {m_nx, 1'b0} == {1'b0, sf};
  assign o_busy    = (state != IDLE);

  always_comb begin
    msg_fin          = msg_sr;
    msg_fin[bit_cnt] = dec_bit;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state <= IDLE;
    else        state <= state_nx;
  end

  // Any i_start resyncs, whatever the state; a bad i_sf leaves the block idle.
  always_comb begin
    state_nx = state;
    if (start_ok)       state_nx = REF;
    else if (start_bad) state_nx = IDLE;
    else begin
      case (state)
        REF:  if (i_en && chip_last) state_nx = DATA;
        DATA: if (i_en && chip_last) state_nx = (bit_cnt == LAST_BIT) ? DONE : REF;
        DONE: state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      sf          <= '0;
      sf_last     <= '0;
      chip_cnt    <= '0;
      bit_cnt     <= '0;
      mis         <= '0;
      ref_buf     <= '0;
      msg_sr      <= '0;
      o_bit       <= 1'b0;
      o_bit_valid <= 1'b0;
      o_msg       <= '0;
      o_msg_valid <= 1'b0;
      o_err       <= 1'b0;
`ifdef RX_METRIC_EN
      o_metric    <= '0;
      o_ambig     <= 1'b0;
`endif
    end else begin
      o_bit_valid <= 1'b0;
      o_msg_valid <= 1'b0;
      o_err       <= start_bad;
      if (i_start) begin
        chip_cnt <= '0;
        bit_cnt  <= '0;
        mis      <= '0;
        msg_sr   <= '0;
        if (sf_ok) begin
          sf      <= i_sf;
          sf_last <= sf_dec[CW-1:0];
`ifdef RX_METRIC_EN
          o_ambig <= 1'b0;
`endif
        end
      end else if (i_en && state == REF) begin
        ref_buf[chip_cnt] <= i_rx;
        chip_cnt          <= chip_last ? '0 : chip_cnt + 1'b1;
      end else if (i_en && state == DATA) begin
        chip_cnt <= chip_last ? '0 : chip_cnt + 1'b1;
        if (chip_last) begin
          mis             <= '0;
          msg_sr[bit_cnt] <= dec_bit;
          bit_cnt         <= bit_cnt + 1'b1;
          o_bit           <= dec_bit;
          o_bit_valid     <= 1'b1;
`ifdef RX_METRIC_EN
          o_metric        <= m_nx;
          if (dec_tie) o_ambig <= 1'b1;
`endif
          // Publish alongside the final bit so o_msg_valid lines up with its o_bit_valid.
          if (bit_cnt == LAST_BIT) begin
            o_msg       <= msg_fin;
            o_msg_valid <= 1'b1;
          end
        end else begin
          mis <= m_nx;
        end
      end
    end
  end

endmodule
